// File: rtl/fruit_manager_if.sv
// Frame/event bus of the fruit manager: frame timing and per-slot player
// events in, per-slot position, draw enable and status out.
interface fruit_manager_if #(
    parameter int NUM_FRUITS = 5
);
    logic                  startOfFrame;
    logic [NUM_FRUITS-1:0] monkeyCollision;
    logic [NUM_FRUITS-1:0] dropRequest;
    logic [10:0]           random_X;
    logic signed [10:0]    topLeftX [NUM_FRUITS];
    logic signed [10:0]    topLeftY [NUM_FRUITS];
    logic [NUM_FRUITS-1:0] drawFruit;
    logic [NUM_FRUITS-1:0] fruitEaten;
    logic [NUM_FRUITS-1:0] fallHit;

    modport master (
        output startOfFrame, monkeyCollision, dropRequest, random_X,
        input  topLeftX, topLeftY, drawFruit, fruitEaten, fallHit
    );

    modport slave (
        input  startOfFrame, monkeyCollision, dropRequest, random_X,
        output topLeftX, topLeftY, drawFruit, fruitEaten, fallHit
    );
endinterface

// File: rtl/fruit_manager.sv
// Fruit slot manager: places fruits at random X one per frame, lets them fall
// on request, scores collisions and respawns eaten slots after a fixed delay.
module fruit_manager #(
    parameter int NUM_FRUITS     = 5,
    parameter int Y_BASE         = 160,
    parameter int Y_STEP         = 40,
    parameter int RESPAWN_FRAMES = 90,
    parameter int FALL_SPEED     = 4,
    parameter int FLOOR_Y        = 447
) (
    input  logic           clk,
    input  logic           resetN,
    fruit_manager_if.slave bus
);
    localparam logic [10:0]        X_MAX      = 11'd607;
    localparam logic signed [10:0] FALL_STEP  = 11'(FALL_SPEED);
    localparam logic signed [10:0] FLOOR      = 11'(FLOOR_Y);
    localparam logic [7:0]         RESPAWN_LD = 8'(RESPAWN_FRAMES);

    typedef enum logic [1:0] {UNPLACED, ACTIVE, FALLING, EATEN} slot_state_e;

    slot_state_e        st_q  [NUM_FRUITS];
    slot_state_e        st_d  [NUM_FRUITS];
    logic signed [10:0] x_q   [NUM_FRUITS];
    logic signed [10:0] x_d   [NUM_FRUITS];
    logic signed [10:0] y_q   [NUM_FRUITS];
    logic signed [10:0] y_d   [NUM_FRUITS];
    logic signed [10:0] tlx_q [NUM_FRUITS];
    logic signed [10:0] tly_q [NUM_FRUITS];
    logic [7:0]         cnt_q [NUM_FRUITS];
    logic [7:0]         cnt_d [NUM_FRUITS];
    logic [NUM_FRUITS-1:0] elig_q, elig_d;
    logic [NUM_FRUITS-1:0] eaten_q, eaten_d;
    logic [NUM_FRUITS-1:0] draw, fall;
    logic                  sof_q;
    logic                  placed;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sof_q   <= 1'b0;
            elig_q  <= '0;
            eaten_q <= '0;
            for (int unsigned i = 0; i < NUM_FRUITS; i++) begin
                st_q[i]  <= UNPLACED;
                x_q[i]   <= '0;
                y_q[i]   <= '0;
                tlx_q[i] <= '0;
                tly_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            sof_q   <= bus.startOfFrame;
            elig_q  <= elig_d;
            eaten_q <= eaten_d;
            for (int unsigned i = 0; i < NUM_FRUITS; i++) begin
                st_q[i]  <= st_d[i];
                x_q[i]   <= x_d[i];
                y_q[i]   <= y_d[i];
                cnt_q[i] <= cnt_d[i];
                if (sof_q) begin
                    tlx_q[i] <= x_d[i];
                    tly_q[i] <= y_d[i];
                end
            end
        end
    end

    always_comb begin
        placed  = 1'b0;
        elig_d  = elig_q;
        eaten_d = '0;
        for (int unsigned i = 0; i < NUM_FRUITS; i++) begin
            st_d[i]  = st_q[i];
            x_d[i]   = x_q[i];
            y_d[i]   = y_q[i];
            cnt_d[i] = cnt_q[i];

            if ((st_q[i] == ACTIVE || st_q[i] == FALLING) && bus.monkeyCollision[i]) begin
                st_d[i]    = EATEN;
                cnt_d[i]   = RESPAWN_LD;
                eaten_d[i] = 1'b1;
            end else if (st_q[i] == ACTIVE && bus.dropRequest[i]) begin
                st_d[i] = FALLING;
            end

            // Events resolve first; the frame step then acts on the resulting state.
            if (bus.startOfFrame) begin
                elig_d[i] = (st_q[i] == UNPLACED);
                if (st_d[i] == FALLING) begin
                    y_d[i] = y_q[i] + FALL_STEP;
                    if (y_d[i] >= FLOOR) begin
                        st_d[i]  = EATEN;
                        cnt_d[i] = RESPAWN_LD;
                    end
                end else if (st_d[i] == EATEN) begin
                    cnt_d[i] = cnt_d[i] - 8'd1;
                    if (cnt_d[i] == 8'd0) begin
                        st_d[i] = UNPLACED;
                    end
                end
            end

            // Only slots already unplaced at this frame's start may be placed now.
            if (sof_q && !placed && st_q[i] == UNPLACED && elig_q[i]) begin
                placed  = 1'b1;
                st_d[i] = ACTIVE;
                x_d[i]  = (bus.random_X > X_MAX) ? X_MAX : bus.random_X;
                y_d[i]  = 11'(Y_BASE + i * Y_STEP);
            end
        end
    end

    always_comb begin
        draw = '0;
        fall = '0;
        for (int unsigned i = 0; i < NUM_FRUITS; i++) begin
            draw[i] = (st_q[i] == ACTIVE) || (st_q[i] == FALLING);
            fall[i] = (st_q[i] == FALLING);
        end
    end

    for (genvar g = 0; g < NUM_FRUITS; g++) begin : g_pos
        assign bus.topLeftX[g] = tlx_q[g];
        assign bus.topLeftY[g] = tly_q[g];
    end

    assign bus.drawFruit  = draw;
    assign bus.fallHit    = fall;
    assign bus.fruitEaten = eaten_q;
endmodule

// File: doc/fruit_manager.md
FRUIT_MANAGER -- requirements
Module: fruit_manager

Interface
REQ-001 SHALL have parameter NUM_FRUITS, default 5, number of fruit slots (legal range 1..8).
REQ-002 SHALL have parameter Y_BASE, default 160, topLeftY of slot 0 in pixels.
REQ-003 SHALL have parameter Y_STEP, default 40, Y spacing between consecutive slots in pixels.
REQ-004 SHALL have parameter RESPAWN_FRAMES, default 90, frames a slot stays eaten before re-placement (legal range 1..255).
REQ-005 SHALL have parameter FALL_SPEED, default 4, pixels per frame added to Y while a slot is falling.
REQ-006 SHALL have parameter FLOOR_Y, default 447, Y at or beyond which a falling fruit is removed.
REQ-007 SHALL have port clk, input, 1 bit, the single system clock.
REQ-008 SHALL have port resetN, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port startOfFrame, input, 1 bit, one-cycle pulse at each frame start.
REQ-010 SHALL have port monkeyCollision, input, NUM_FRUITS bits, per-slot collision with the player.
REQ-011 SHALL have port dropRequest, input, NUM_FRUITS bits, per-slot request to start falling.
REQ-012 SHALL have port random_X, input, 11 bits, random X source, valid one cycle after startOfFrame.
REQ-013 SHALL have port topLeftX, output, NUM_FRUITS x 11 bits signed, per-slot X.
REQ-014 SHALL have port topLeftY, output, NUM_FRUITS x 11 bits signed, per-slot Y.
REQ-015 SHALL have port drawFruit, output, NUM_FRUITS bits, per-slot draw enable.
REQ-016 SHALL have port fruitEaten, output, NUM_FRUITS bits, one-cycle pulse per slot on a scoring collision.
REQ-017 SHALL have port fallHit, output, NUM_FRUITS bits, level, high while the slot is FALLING.

Function
REQ-018 SHALL run one state machine per slot with states UNPLACED, ACTIVE, FALLING, EATEN.
REQ-019 SHALL place at most one UNPLACED slot per frame, choosing the lowest-index UNPLACED slot.
REQ-020 SHALL perform the placement on the cycle after startOfFrame and SHALL sample random_X on that cycle.
REQ-021 SHALL set X = min(random_X, 607) and Y = Y_BASE + i*Y_STEP on placement, then move the slot to ACTIVE.
REQ-022 SHALL move ACTIVE to FALLING on dropRequest[i]=1.
REQ-023 SHALL add FALL_SPEED to Y on each startOfFrame while the slot is FALLING.
REQ-024 SHALL move FALLING to EATEN without pulsing fruitEaten when Y >= FLOOR_Y.
REQ-025 SHALL move ACTIVE or FALLING to EATEN on monkeyCollision[i]=1 and pulse fruitEaten[i] for exactly one cycle.
REQ-026 SHALL load a per-slot 8-bit counter with RESPAWN_FRAMES on entry to EATEN.
REQ-027 SHALL decrement that counter on each startOfFrame and SHALL move the slot to UNPLACED when it reaches 0.
REQ-028 SHALL ignore monkeyCollision and dropRequest in the UNPLACED and EATEN states.
REQ-029 SHALL give collision priority when collision and dropRequest arrive in the same cycle: the slot goes to EATEN and fruitEaten pulses.
REQ-030 SHALL update topLeftX and topLeftY only on the cycle after startOfFrame, from the post-placement and post-fall state.
REQ-031 SHALL set drawFruit[i]=1 exactly when the slot is ACTIVE or FALLING, updated every cycle.
REQ-032 SHALL drive drawFruit[i] to 0 on the cycle after the collision edge, so one fruit scores at most once.
REQ-033 SHALL apply a collision and a startOfFrame in the same cycle in this order: the collision first, then the frame step on the resulting state.
REQ-034 SHALL treat the EATEN-to-UNPLACED transition and the placement as separate frames (minimum UNPLACED dwell of one frame).

Reset
REQ-035 SHALL, while resetN=0 (asynchronous), put every slot in UNPLACED and clear topLeftX, topLeftY, drawFruit, fruitEaten, fallHit and all counters to 0.
REQ-036 SHALL, after resetN deasserts mid-operation, restart placement from slot 0 on the next frame.

Verification
REQ-037 Bench SHALL cover: reset, 5 frames with random_X=100,200,300,400,700 -> slots 0..4 ACTIVE with X=100,200,300,400,607 and Y=160,200,240,280,320.
REQ-038 Bench SHALL cover: collision on slot 2 -> fruitEaten=00100 for 1 cycle, drawFruit[2]=0 next cycle, re-placed 91 frames later.
REQ-039 Bench SHALL cover: dropRequest on slot 4 (Y=320) -> Y steps +4 per frame, slot leaves at Y=448 after 32 frames, no fruitEaten pulse.
REQ-040 Bench SHALL cover: collision and dropRequest on slot 1 in the same cycle -> EATEN, fruitEaten[1] pulses, fallHit[1] stays 0.
REQ-041 Bench SHALL cover: collision held high for 10 cycles on slot 0 -> exactly one fruitEaten pulse.
REQ-042 Bench SHALL cover: reset asserted while slot 3 is FALLING -> all outputs 0 immediately, slot 0 placed on the first frame after reset deasserts.
